// File: rtl/usb_uart_hex_tx.sv
// usb_uart_hex_tx: device-to-host hex line transmitter for the USB serial
// pipeline. Each word accepted on the word_in valid/ready port is sent to
// usb_uart as ASCII hex digits, most-significant nibble first, followed by
// CR LF (or LF only). Everything runs on clk_48mhz.
//
// Optional feature: define USB_UART_HEX_TX_PREFIX_EN to start every line
// with "0x". The PREFIX state only exists in that build.
//
// Handshake rules, for both ports:
//   - A transfer happens on a rising edge where valid && ready are both high.
//   - uart_in_valid/uart_in_data are registered. Once valid is raised, they
//     stay unchanged until the byte transfers.
//   - word_in_ready is high only in IDLE, and not while reset is high. It
//     depends only on registered state and reset.
module usb_uart_hex_tx #(
  parameter int WORD_WIDTH   = 32,
  parameter bit UPPERCASE    = 1'b1,
  parameter bit NEWLINE_CRLF = 1'b1
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_in_valid,
  output logic                  word_in_ready,
  output logic [7:0]            uart_in_data,
  output logic                  uart_in_valid,
  input  logic                  uart_in_ready,
  output logic                  busy,
  output logic [15:0]           words_sent
);

  localparam int NIB = WORD_WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

`ifdef USB_UART_HEX_TX_PREFIX_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PREFIX = 3'd1,
    HEX    = 3'd2,
    CR     = 3'd3,
    LF     = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HEX  = 3'd2,
    CR   = 3'd3,
    LF   = 3'd4
  } state_t;
`endif

  // The current state is visible through the hierarchy for checkers.
  state_t                state;
  // Holds the digits not yet loaded into uart_in_data, top-aligned.
  logic [WORD_WIDTH-1:0] shreg;
  // Index of the digit now in uart_in_data.
  logic [CW-1:0]         nib_cnt;
`ifdef USB_UART_HEX_TX_PREFIX_EN
  // 0 while '0' is pending, 1 while 'x' is pending.
  logic                  pfx_cnt;
`endif
  logic                  byte_xfer;

  // Map one nibble to its ASCII hex character.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] n8;
    n8 = {4'h0, n};
    if (n < 4'd10)  return 8'h30 + n8;
    else if (UPPERCASE) return 8'h37 + n8;  // 'A' - 10
    else            return 8'h57 + n8;      // 'a' - 10
  endfunction

  assign byte_xfer     = uart_in_valid && uart_in_ready;
  assign word_in_ready = (state == IDLE) && !reset;
  assign busy          = (state != IDLE);

  // Line sequencer: captures a word, then steps through prefix, digits and
  // the line terminator. The next byte is loaded on the same edge as the
  // current byte transfers, so there are no gaps inside a line.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= '0;
      nib_cnt       <= '0;
      uart_in_data  <= 8'h00;
      uart_in_valid <= 1'b0;
      words_sent    <= 16'h0000;
`ifdef USB_UART_HEX_TX_PREFIX_EN
      pfx_cnt       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (word_in_valid) begin
            nib_cnt       <= '0;
            uart_in_valid <= 1'b1;
`ifdef USB_UART_HEX_TX_PREFIX_EN
            shreg         <= word_in;
            uart_in_data  <= 8'h30;
            pfx_cnt       <= 1'b0;
            state         <= PREFIX;
`else
            shreg         <= word_in << 4;
            uart_in_data  <= hex_char(word_in[WORD_WIDTH-1 -: 4]);
            state         <= HEX;
`endif
          end
        end

`ifdef USB_UART_HEX_TX_PREFIX_EN
        PREFIX: begin
          if (byte_xfer) begin
            if (!pfx_cnt) begin
              uart_in_data <= 8'h78;
              pfx_cnt      <= 1'b1;
            end else begin
              uart_in_data <= hex_char(shreg[WORD_WIDTH-1 -: 4]);
              shreg        <= shreg << 4;
              state        <= HEX;
            end
          end
        end
`endif

        HEX: begin
          if (byte_xfer) begin
            if (nib_cnt == LAST_NIB) begin
              uart_in_data <= NEWLINE_CRLF ? 8'h0D : 8'h0A;
              state        <= NEWLINE_CRLF ? CR : LF;
            end else begin
              uart_in_data <= hex_char(shreg[WORD_WIDTH-1 -: 4]);
              shreg        <= shreg << 4;
              nib_cnt      <= nib_cnt + CW'(1);
            end
          end
        end

        CR: begin
          if (byte_xfer) begin
            uart_in_data <= 8'h0A;
            state        <= LF;
          end
        end

        LF: begin
          if (byte_xfer) begin
            uart_in_valid <= 1'b0;
            words_sent    <= words_sent + 16'd1;
            state         <= IDLE;
          end
        end

        default: begin
          uart_in_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_uart_hex_tx.sv
// Testbench for usb_uart_hex_tx. Instantiates the default configuration and
// a narrow lowercase LF-only configuration (WORD_WIDTH=8). Expected bytes
// come from a reference line model and from a table of expected hex text.
module tb_usb_uart_hex_tx;

`ifdef USB_UART_HEX_TX_PREFIX_EN
  localparam int PFX = 2;
`else
  localparam int PFX = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk_48mhz = 1'b0;
  always #10 clk_48mhz = ~clk_48mhz;

  logic        reset = 1'b1;
  logic [31:0] word_in = '0;
  logic        word_in_valid = 1'b0;
  logic        word_in_ready;
  logic [7:0]  uart_in_data;
  logic        uart_in_valid;
  logic        uart_in_ready;
  logic        busy;
  logic [15:0] words_sent;

  // uart_in_ready is either driven by hand or by an automatic pattern.
  int   ready_mode = 3;   // 0 always high, 1 toggle, 2 random, 3 manual
  logic manual_ready = 1'b1;
  logic auto_ready = 1'b1;
  assign uart_in_ready = (ready_mode == 3) ? manual_ready : auto_ready;

  usb_uart_hex_tx dut (
    .clk_48mhz     (clk_48mhz),
    .reset         (reset),
    .word_in       (word_in),
    .word_in_valid (word_in_valid),
    .word_in_ready (word_in_ready),
    .uart_in_data  (uart_in_data),
    .uart_in_valid (uart_in_valid),
    .uart_in_ready (uart_in_ready),
    .busy          (busy),
    .words_sent    (words_sent)
  );

  logic [7:0]  word8 = '0;
  logic        valid8 = 1'b0;
  logic        ready8_out;
  logic [7:0]  data8;
  logic        uvalid8;
  logic        uready8 = 1'b1;
  logic        busy8;
  logic [15:0] ws8;

  usb_uart_hex_tx #(
    .WORD_WIDTH   (8),
    .UPPERCASE    (1'b0),
    .NEWLINE_CRLF (1'b0)
  ) dut8 (
    .clk_48mhz     (clk_48mhz),
    .reset         (reset),
    .word_in       (word8),
    .word_in_valid (valid8),
    .word_in_ready (ready8_out),
    .uart_in_data  (data8),
    .uart_in_valid (uvalid8),
    .uart_in_ready (uready8),
    .busy          (busy8),
    .words_sent    (ws8)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int exp_ws   = 0;
  logic [7:0] exp_q[$];
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference line model: byte k of the line carrying word w.
  function automatic logic [7:0] line_byte(input logic [63:0] w, input int nib,
                                           input bit upper, input bit crlf, input int k);
    string s;
    int d;
    int n;
    s = upper ? "0123456789ABCDEF" : "0123456789abcdef";
    if (k < PFX) return (k == 0) ? 8'h30 : 8'h78;
    d = k - PFX;
    if (d < nib) begin
      n = int'((w >> ((nib - 1 - d) * 4)) & 64'hF);
      return s[n];
    end
    if (crlf && d == nib) return 8'h0D;
    return 8'h0A;
  endfunction

  function automatic int line_len(input int nib, input bit crlf);
    return PFX + nib + (crlf ? 2 : 1);
  endfunction

  localparam int L32 = PFX + 8 + 2;

  // Automatic ready pattern generator.
  initial begin
    forever begin
      @(posedge clk_48mhz); #1;
      case (ready_mode)
        0:       auto_ready = 1'b1;
        1:       auto_ready = !auto_ready;
        2:       auto_ready = 1'($urandom_range(0, 1));
        default: auto_ready = 1'b1;
      endcase
    end
  end

  // Scoreboard monitor: pops an expected byte on every byte transfer and
  // checks that a stalled byte stays put.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(negedge clk_48mhz) begin
    if (mon_en && !reset) begin
      if (prev_stall) begin
        check("sb stall valid held", uart_in_valid, 1);
        check("sb stall data held", uart_in_data, prev_data);
      end
      if (uart_in_valid && uart_in_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb extra byte: got %0h expected none", uart_in_data);
        end else begin
          check("sb byte", uart_in_data, exp_q.pop_front());
        end
      end
    end
    prev_stall = uart_in_valid && !uart_in_ready;
    prev_data  = uart_in_data;
  end

  // ---------------- driver tasks ----------------
  // Present a word and return at #1 after the edge that accepted it.
  task automatic accept_word(input logic [31:0] w);
    int t;
    t = 0;
    word_in       = w;
    word_in_valid = 1'b1;
    @(negedge clk_48mhz);
    while (!word_in_ready && t < 60) begin
      @(negedge clk_48mhz);
      t++;
    end
    check("accept ready seen", word_in_ready, 1);
    @(posedge clk_48mhz); #1;
  endtask

  // Collect nbytes of a default-configuration line, one check per cycle.
  // Optionally stalls uart_in_ready for stall_len cycles once byte stall_k
  // is pending. Must be called at #1 after the accepting edge.
  task automatic collect_line(input logic [31:0] w, input int nbytes,
                              input int stall_k, input int stall_len, input string name);
    int k;
    int cyc;
    int left;
    k = 0;
    cyc = 0;
    left = stall_len;
    while (k < nbytes && cyc < 100) begin
      if (k == stall_k && left > 0) begin
        manual_ready = 1'b0;
        left--;
      end else begin
        manual_ready = 1'b1;
      end
      @(negedge clk_48mhz);
      check({name, " valid"}, uart_in_valid, 1);
      check({name, " data"}, uart_in_data, line_byte(64'(w), 8, 1'b1, 1'b1, k));
      check({name, " busy"}, busy, 1);
      if (uart_in_ready) k++;
      @(posedge clk_48mhz); #1;
      cyc++;
    end
    manual_ready = 1'b1;
    check({name, " byte count"}, k, nbytes);
  endtask

  // Expect the one idle cycle that follows a complete line.
  task automatic check_idle(input string name);
    @(negedge clk_48mhz);
    check({name, " idle valid"}, uart_in_valid, 0);
    check({name, " idle ready"}, word_in_ready, 1);
    check({name, " idle busy"}, busy, 0);
    check({name, " words_sent"}, words_sent, 16'(exp_ws));
  endtask

  // ---------------- table ----------------
  typedef struct {
    logic [31:0] word;
    int          mode;
    string       exp_hex;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int busy_cnt;
    int k8;
    logic [31:0] w;

    vecs[0] = '{32'h1234ABCD, 0, "1234ABCD"};
    vecs[1] = '{32'h00000000, 1, "00000000"};
    vecs[2] = '{32'hFFFFFFFF, 2, "FFFFFFFF"};
    vecs[3] = '{32'hDEADBEEF, 1, "DEADBEEF"};
    vecs[4] = '{32'h0000000A, 0, "0000000A"};
    vecs[5] = '{32'h89ABCDEF, 2, "89ABCDEF"};
    vecs[6] = '{32'h76543210, 1, "76543210"};
    vecs[7] = '{32'h5A5AC3C3, 2, "5A5AC3C3"};

    // Reset state.
    repeat (3) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    check("reset valid", uart_in_valid, 0);
    check("reset data", uart_in_data, 8'h00);
    check("reset busy", busy, 0);
    check("reset words_sent", words_sent, 0);
    check("reset word_in_ready", word_in_ready, 0);
    check("reset dut8 ready", ready8_out, 0);
    @(posedge clk_48mhz); #1;
    reset = 1'b0;
    @(negedge clk_48mhz);
    check("post reset word_in_ready", word_in_ready, 1);

    // Basic line, ready held high: bytes on consecutive cycles.
    @(posedge clk_48mhz); #1;
    accept_word(32'h1234ABCD);
    word_in_valid = 1'b0;
    word_in = 32'h99999999;          // changes while busy are ignored
    collect_line(32'h1234ABCD, L32, -1, 0, "basic");
    exp_ws = 1;
    check_idle("basic");

    // Narrow lowercase LF-only instance: word 0xAF.
    @(posedge clk_48mhz); #1;
    word8 = 8'hAF;
    valid8 = 1'b1;
    t = 0;
    @(negedge clk_48mhz);
    while (!ready8_out && t < 20) begin
      @(negedge clk_48mhz);
      t++;
    end
    @(posedge clk_48mhz); #1;
    valid8 = 1'b0;
    word8 = 8'h00;
    busy_cnt = 0;
    k8 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_48mhz);
      if (busy8) busy_cnt++;
      if (uvalid8) begin
        check("narrow byte", data8, line_byte(64'hAF, 2, 1'b0, 1'b0, k8));
        k8++;
      end
    end
    check("narrow busy cycles", busy_cnt, line_len(2, 1'b0));
    check("narrow byte count", k8, line_len(2, 1'b0));
    check("narrow words_sent", ws8, 1);

    // Stall while the third digit is pending.
    @(posedge clk_48mhz); #1;
    accept_word(32'h1234ABCD);
    word_in_valid = 1'b0;
    collect_line(32'h1234ABCD, L32, PFX + 2, 5, "stall");
    exp_ws++;
    check_idle("stall");

    // word_in_valid held high: back-to-back words with one idle cycle.
    @(posedge clk_48mhz); #1;
    accept_word(32'h00000000);
    word_in = 32'hFFFFFFFF;          // still valid, must wait for IDLE
    collect_line(32'h00000000, L32, -1, 0, "b2b first");
    exp_ws++;
    check_idle("b2b");
    @(posedge clk_48mhz); #1;        // second word taken on this edge
    word_in_valid = 1'b0;
    collect_line(32'hFFFFFFFF, L32, -1, 0, "b2b second");
    exp_ws++;
    check_idle("b2b second");

    // Reset after 4 bytes aborts the line.
    @(posedge clk_48mhz); #1;
    accept_word(32'h1234ABCD);
    word_in_valid = 1'b0;
    collect_line(32'h1234ABCD, 4, -1, 0, "partial");
    reset = 1'b1;
    @(negedge clk_48mhz);
    @(negedge clk_48mhz);
    check("abort valid", uart_in_valid, 0);
    check("abort busy", busy, 0);
    check("abort words_sent", words_sent, 0);
    check("abort ready during reset", word_in_ready, 0);
    @(posedge clk_48mhz); #1;
    reset = 1'b0;
    exp_ws = 0;
    accept_word(32'hCAFE0123);
    word_in_valid = 1'b0;
    collect_line(32'hCAFE0123, L32, -1, 0, "after abort");
    exp_ws++;
    check_idle("after abort");

    // Table-driven scoreboard run under different ready patterns.
    mon_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk_48mhz); #1;
      if (i < 8) begin
        w = vecs[i].word;
        ready_mode = vecs[i].mode;
        if (PFX != 0) begin
          exp_q.push_back(8'h30);
          exp_q.push_back(8'h78);
        end
        for (int j = 0; j < 8; j++) exp_q.push_back(vecs[i].exp_hex[j]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end else begin
        w = $urandom;
        ready_mode = $urandom_range(0, 2);
        for (int j = 0; j < L32; j++) exp_q.push_back(line_byte(64'(w), 8, 1'b1, 1'b1, j));
      end
      accept_word(w);
      word_in_valid = 1'b0;
      word_in = $urandom;
      exp_ws++;
      t = 0;
      while ((exp_q.size() != 0 || busy) && t < 300) begin
        @(negedge clk_48mhz);
        t++;
      end
      check("sb drained", exp_q.size(), 0);
      @(negedge clk_48mhz);
      check("sb words_sent", words_sent, 16'(exp_ws));
    end
    mon_en = 1'b0;
    ready_mode = 3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
